// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for a MIPS-subset datapath (fetch/decode/execute/mem/writeback).
// Optional performance counters are compiled in when PERF_CNT_EN is defined.
module multicycle_ctrl_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op_in,
    input  logic [5:0]         func_in,
    input  logic               zero_in,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         ALUOp,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
`ifdef PERF_CNT_EN
    output logic [31:0]        instr_count,
    output logic [31:0]        cycle_count,
`endif
    output logic [STATE_W-1:0] state_out
);

    typedef enum logic [STATE_W-1:0] {
        RST    = STATE_W'(0),
        FETCH  = STATE_W'(1),
        DECODE = STATE_W'(2),
        MADDR  = STATE_W'(3),
        MREAD  = STATE_W'(4),
        MWB    = STATE_W'(5),
        MWRITE = STATE_W'(6),
        RXEC   = STATE_W'(7),
        RWB    = STATE_W'(8),
        IXEC   = STATE_W'(9),
        IWB    = STATE_W'(10),
        BR     = STATE_W'(11),
        JMP    = STATE_W'(12)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RST;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = RST;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ALUOp      = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state_reg)
            RST: state_next = FETCH;
            FETCH: begin
                // PC+4 is computed while the instruction read is pending
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_next = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (op_in)
                    OP_LW, OP_SW: state_next = MADDR;
                    OP_ADDI:      state_next = IXEC;
                    OP_BEQ:       state_next = BR;
                    OP_J:         state_next = JMP;
                    OP_RTYPE:     state_next = (func_in == 6'd0) ? FETCH : RXEC;
                    default:      state_next = FETCH;
                endcase
            end
            MADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (op_in == OP_LW) begin
                    state_next = MREAD;
                end else if (op_in == OP_SW) begin
                    state_next = MWRITE;
                end else begin
                    state_next = FETCH;
                end
            end
            MREAD: begin
                mem_req    = 1'b1;
                i_or_d     = 1'b1;
                state_next = mem_ready ? MWB : MREAD;
            end
            MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = FETCH;
            end
            MWRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                state_next = mem_ready ? FETCH : MWRITE;
            end
            RXEC: begin
                alu_src_a  = 1'b1;
                ALUOp      = 2'b10;
                state_next = RWB;
            end
            RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = FETCH;
            end
            IXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = IWB;
            end
            IWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BR: begin
                alu_src_a  = 1'b1;
                ALUOp      = 2'b01;
                pc_src     = 2'b01;
                pc_write   = zero_in;
                state_next = FETCH;
            end
            JMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                state_next = FETCH;
            end
            default: state_next = RST;
        endcase
    end

    assign state_out = state_reg;

`ifdef PERF_CNT_EN
    // An instruction retires whenever FETCH is entered from a real instruction state
    logic instr_done;
    assign instr_done = (state_next == FETCH) && (state_reg != RST) && (state_reg != FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= 32'd0;
            cycle_count <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (instr_done) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed scoreboard bench for multicycle_ctrl_fsm; expected control vectors are queued per cycle.
// Counter checks are compiled in when PERF_CNT_EN is defined.
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  op_in;
    logic [5:0]  func_in;
    logic        zero_in;
    logic        mem_ready;
    logic        mem_req, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  ALUOp;
    logic        reg_write, reg_dst, mem_to_reg;
    logic [3:0]  state_out;
`ifdef PERF_CNT_EN
    logic [31:0] instr_count, cycle_count;
`endif

    multicycle_ctrl_fsm #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_in      (op_in),
        .func_in    (func_in),
        .zero_in    (zero_in),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ALUOp      (ALUOp),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
`ifdef PERF_CNT_EN
        .instr_count(instr_count),
        .cycle_count(cycle_count),
`endif
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [18:0] exp_q[$];
    string       tag_q[$];
    logic [18:0] act;

    assign act = {state_out, mem_req, mem_write, i_or_d, ir_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, ALUOp, reg_write, reg_dst, mem_to_reg};

    // Control vector each state must produce, taken from the state table
    function automatic logic [18:0] model(input logic [3:0] st, input logic rdy, input logic z);
        logic mreq, mw, iod, irw, pcw, srca, rw, rd, m2r;
        logic [1:0] pcs, srcb, aop;
        {mreq, mw, iod, irw, pcw, srca, rw, rd, m2r} = '0;
        pcs = 2'b00; srcb = 2'b00; aop = 2'b00;
        case (st)
            4'd1:  begin mreq = 1'b1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            4'd2:  srcb = 2'b11;
            4'd3:  begin srca = 1'b1; srcb = 2'b10; end
            4'd4:  begin mreq = 1'b1; iod = 1'b1; end
            4'd5:  begin rw = 1'b1; m2r = 1'b1; end
            4'd6:  begin mreq = 1'b1; mw = 1'b1; iod = 1'b1; end
            4'd7:  begin srca = 1'b1; aop = 2'b10; end
            4'd8:  begin rw = 1'b1; rd = 1'b1; end
            4'd9:  begin srca = 1'b1; srcb = 2'b10; end
            4'd10: rw = 1'b1;
            4'd11: begin srca = 1'b1; aop = 2'b01; pcs = 2'b01; pcw = z; end
            4'd12: begin pcs = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
        return {st, mreq, mw, iod, irw, pcw, pcs, srca, srcb, aop, rw, rd, m2r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue the expectation, compare at the falling edge
    task automatic cyc(input string tag, input logic [3:0] st, input logic rdy, input logic z);
        logic [18:0] e;
        string       t;
        mem_ready = rdy;
        zero_in   = z;
        exp_q.push_back(model(st, rdy, z));
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {13'd0, act}, {13'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
        op_in   = op;
        func_in = fn;
    endtask

    initial begin
        rst_n = 1'b0;
        set_ir(6'h00, 6'h00);
        zero_in   = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {13'd0, act}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset_release_state", {28'd0, state_out}, 32'd0);
        @(posedge clk);
        #1;

        // ADD
        set_ir(6'h00, 6'h20);
        cyc("add_fetch", 4'd1, 1'b1, 1'b0);
        cyc("add_decode", 4'd2, 1'b1, 1'b0);
        cyc("add_rxec", 4'd7, 1'b1, 1'b0);
        cyc("add_rwb", 4'd8, 1'b1, 1'b0);
        // LW, no wait states
        set_ir(6'h23, 6'h00);
        cyc("lw0_fetch", 4'd1, 1'b1, 1'b0);
        cyc("lw0_decode", 4'd2, 1'b1, 1'b0);
        cyc("lw0_maddr", 4'd3, 1'b1, 1'b0);
        cyc("lw0_mread", 4'd4, 1'b1, 1'b0);
        cyc("lw0_mwb", 4'd5, 1'b1, 1'b0);
        // NOP
        set_ir(6'h00, 6'h00);
        cyc("nop_fetch", 4'd1, 1'b1, 1'b0);
        cyc("nop_decode", 4'd2, 1'b1, 1'b0);
`ifdef PERF_CNT_EN
        check("perf_instr_count", instr_count, 32'd3);
        check("perf_cycle_count", cycle_count, 32'd12);
`endif

        // LW with three wait cycles in MREAD
        set_ir(6'h23, 6'h00);
        cyc("lw3_fetch", 4'd1, 1'b1, 1'b0);
        cyc("lw3_decode", 4'd2, 1'b1, 1'b0);
        cyc("lw3_maddr", 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("lw3_mread_wait", 4'd4, 1'b0, 1'b0);
        cyc("lw3_mread_done", 4'd4, 1'b1, 1'b0);
        cyc("lw3_mwb", 4'd5, 1'b1, 1'b0);
        // SW with one wait cycle
        set_ir(6'h2B, 6'h00);
        cyc("sw_fetch", 4'd1, 1'b1, 1'b0);
        cyc("sw_decode", 4'd2, 1'b1, 1'b0);
        cyc("sw_maddr", 4'd3, 1'b1, 1'b0);
        cyc("sw_mwrite_wait", 4'd6, 1'b0, 1'b0);
        cyc("sw_mwrite_done", 4'd6, 1'b1, 1'b0);
        // ADDI
        set_ir(6'h08, 6'h00);
        cyc("addi_fetch", 4'd1, 1'b1, 1'b0);
        cyc("addi_decode", 4'd2, 1'b1, 1'b0);
        cyc("addi_ixec", 4'd9, 1'b1, 1'b0);
        cyc("addi_iwb", 4'd10, 1'b1, 1'b0);
        // BEQ taken then not taken; mem_ready low in BR must be ignored
        set_ir(6'h04, 6'h00);
        cyc("beq1_fetch", 4'd1, 1'b1, 1'b1);
        cyc("beq1_decode", 4'd2, 1'b1, 1'b1);
        cyc("beq1_br", 4'd11, 1'b0, 1'b1);
        cyc("beq0_fetch", 4'd1, 1'b1, 1'b0);
        cyc("beq0_decode", 4'd2, 1'b1, 1'b0);
        cyc("beq0_br", 4'd11, 1'b1, 1'b0);
        // J
        set_ir(6'h02, 6'h00);
        cyc("j_fetch", 4'd1, 1'b1, 1'b0);
        cyc("j_decode", 4'd2, 1'b1, 1'b0);
        cyc("j_jmp", 4'd12, 1'b1, 1'b0);
        // Illegal opcode behaves as NOP
        set_ir(6'h3F, 6'h00);
        cyc("ill_fetch", 4'd1, 1'b1, 1'b0);
        cyc("ill_decode", 4'd2, 1'b1, 1'b0);
        // NOP with a stalled fetch
        set_ir(6'h00, 6'h00);
        cyc("nopw_fetch_wait", 4'd1, 1'b0, 1'b0);
        cyc("nopw_fetch_done", 4'd1, 1'b1, 1'b0);
        cyc("nopw_decode", 4'd2, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a pending read
        set_ir(6'h23, 6'h00);
        cyc("rst_lw_fetch", 4'd1, 1'b1, 1'b0);
        cyc("rst_lw_decode", 4'd2, 1'b1, 1'b0);
        cyc("rst_lw_maddr", 4'd3, 1'b1, 1'b0);
        mem_ready = 1'b0;
        #2;
        check("rst_pre_mem_req", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {13'd0, act}, 32'd0);
`ifdef PERF_CNT_EN
        check("rst_async_instr", instr_count, 32'd0);
        check("rst_async_cycle", cycle_count, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_hold_state", {28'd0, state_out}, 32'd0);
        @(posedge clk);
        #1;
        cyc("post_rst_fetch", 4'd1, 1'b1, 1'b0);
        cyc("post_rst_decode", 4'd2, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
